// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multi-cycle RV32I sequencer sharing one memory port and one ALU
module multicycle_ctrl #(
    parameter int TO_W    = 8,
    parameter int TIMEOUT = 200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    input  logic       brEq,
    input  logic       brLt,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       addr_sel,
    output logic       ir_write,
    output logic       pc_write,
    output logic       pc_src,
    output logic       alu_src_a,
    output logic       alu_src_b,
    output logic [3:0] ALUop,
    output logic [2:0] immsel,
    output logic       br_un,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic       retire,
    output logic       illegal,
    output logic       bus_err,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        S_RST    = 3'b000,
        S_FETCH  = 3'b001,
        S_DECODE = 3'b010,
        S_EXEC   = 3'b011,
        S_MEM    = 3'b100,
        S_WB     = 3'b101,
        S_TRAP   = 3'b110
    } state_t;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LD    = 7'b0000011;
    localparam logic [6:0] OP_ST    = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    state_t          st;
    logic [TO_W-1:0] wcnt;
    logic            legal;
    logic            taken;

    function automatic logic [3:0] alu_dec(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  alu_dec = alt ? 4'b0001 : 4'b0000;
            3'b001:  alu_dec = 4'b0010;
            3'b010:  alu_dec = 4'b0011;
            3'b011:  alu_dec = 4'b0100;
            3'b100:  alu_dec = 4'b0101;
            3'b101:  alu_dec = alt ? 4'b0111 : 4'b0110;
            3'b110:  alu_dec = 4'b1000;
            default: alu_dec = 4'b1001;
        endcase
    endfunction

    // R-type only admits funct7=0100000 for SUB and SRA
    always_comb begin
        legal = 1'b0;
        case (opcode)
            OP_R:    legal = (funct7 == 7'b0000000) ||
                             (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101));
            OP_BR:   legal = (funct3[2:1] != 2'b01);
            OP_I, OP_LD, OP_ST, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: legal = 1'b1;
            default: legal = 1'b0;
        endcase
    end

    always_comb begin
        taken = 1'b0;
        case (funct3)
            3'b000:          taken = brEq;
            3'b001:          taken = !brEq;
            3'b100, 3'b110:  taken = brLt;
            3'b101, 3'b111:  taken = !brLt;
            default:         taken = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st      <= S_RST;
            wcnt    <= '0;
            illegal <= 1'b0;
            bus_err <= 1'b0;
        end else begin
            case (st)
                S_RST: begin
                    st   <= S_FETCH;
                    wcnt <= '0;
                end
                S_FETCH, S_MEM: begin
                    // a ready on the last allowed wait cycle still completes normally
                    if (mem_ready) begin
                        wcnt <= '0;
                        if (st == S_FETCH)       st <= S_DECODE;
                        else if (opcode == OP_ST) st <= S_FETCH;
                        else                     st <= S_WB;
                    end else if (wcnt == TO_LAST) begin
                        bus_err <= 1'b1;
                        st      <= S_TRAP;
                    end else begin
                        wcnt <= wcnt + TO_W'(1);
                    end
                end
                S_DECODE: begin
                    if (legal) begin
                        st <= S_EXEC;
                    end else begin
                        illegal <= 1'b1;
                        st      <= S_TRAP;
                    end
                end
                S_EXEC: begin
                    wcnt <= '0;
                    case (opcode)
                        OP_LD, OP_ST:          st <= S_MEM;
                        OP_BR, OP_JAL, OP_JALR: st <= S_FETCH;
                        default:               st <= S_WB;
                    endcase
                end
                S_WB: begin
                    wcnt <= '0;
                    st   <= S_FETCH;
                end
                default: st <= S_TRAP;
            endcase
        end
    end

    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        addr_sel  = 1'b0;
        ir_write  = 1'b0;
        pc_write  = 1'b0;
        pc_src    = 1'b0;
        alu_src_a = 1'b0;
        alu_src_b = 1'b0;
        ALUop     = 4'b0000;
        immsel    = 3'b000;
        br_un     = 1'b0;
        RegWrite  = 1'b0;
        ResultSrc = 2'b00;
        retire    = 1'b0;
        // immediate format stays selected through EXEC, where the ALU consumes it
        if (st == S_DECODE || st == S_EXEC) begin
            case (opcode)
                OP_ST:             immsel = 3'b001;
                OP_BR:             immsel = 3'b010;
                OP_LUI, OP_AUIPC:  immsel = 3'b011;
                OP_JAL:            immsel = 3'b100;
                default:           immsel = 3'b000;
            endcase
        end
        case (st)
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                end
            end
            S_EXEC: begin
                case (opcode)
                    OP_R: ALUop = alu_dec(funct3, funct7[5]);
                    OP_I: begin
                        alu_src_b = 1'b1;
                        ALUop     = alu_dec(funct3, funct7[5] && funct3 == 3'b101);
                    end
                    OP_LD, OP_ST: alu_src_b = 1'b1;
                    OP_BR: begin
                        alu_src_a = 1'b1;
                        alu_src_b = 1'b1;
                        br_un     = funct3[1];
                        pc_write  = taken;
                        pc_src    = taken;
                        retire    = 1'b1;
                    end
                    OP_JAL, OP_JALR: begin
                        alu_src_a = (opcode == OP_JAL);
                        alu_src_b = 1'b1;
                        pc_write  = 1'b1;
                        pc_src    = 1'b1;
                        RegWrite  = 1'b1;
                        ResultSrc = 2'b10;
                        retire    = 1'b1;
                    end
                    OP_LUI: begin
                        alu_src_b = 1'b1;
                        ALUop     = 4'b1010;
                    end
                    OP_AUIPC: begin
                        alu_src_a = 1'b1;
                        alu_src_b = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_MEM: begin
                mem_req  = 1'b1;
                addr_sel = 1'b1;
                mem_we   = (opcode == OP_ST);
                retire   = mem_ready && (opcode == OP_ST);
            end
            S_WB: begin
                RegWrite  = 1'b1;
                ResultSrc = (opcode == OP_LD) ? 2'b01 : 2'b00;
                retire    = 1'b1;
            end
            default: ;
        endcase
    end

    assign state = st;

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Multi-cycle sequencer for the RV32I core datapath. It replaces single-cycle decode with an FSM that time-shares one memory port and one ALU across the fetch, execute, memory and write-back steps.
- It drives PC/IR enables, memory handshake, ALU configuration and register-file write from the latched instruction fields and branch-comparator flags.
- It sits between the IR/PC registers and the shared datapath (ALU, regfile, branch comparator, unified memory).

Parameters:
- TO_W, 8, width of the memory-wait watchdog counter.
- TIMEOUT, 200, maximum cycles in one memory wait before bus error; must be less than 2^TO_W.

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- opcode  in  7  IR[6:0]; valid from DECODE onward.
- funct3  in  3  IR[14:12].
- funct7  in  7  IR[31:25].
- brEq  in  1  comparator: rs1==rs2.
- brLt  in  1  comparator: rs1<rs2, signedness per br_un.
- mem_ready  in  1  memory completes current request this cycle.
- mem_req  out  1  memory request valid.
- mem_we  out  1  write (store) request.
- addr_sel  out  1  0 = PC address, 1 = ALU result address.
- ir_write  out  1  load IR and latch old_pc<=PC.
- pc_write  out  1  PC update enable.
- pc_src  out  1  0 = PC+4, 1 = ALU result.
- alu_src_a  out  1  0 = rs1, 1 = old_pc.
- alu_src_b  out  1  0 = rs2, 1 = immediate.
- ALUop  out  4  0000 ADD, 0001 SUB, 0010 SLL, 0011 SLT, 0100 SLTU, 0101 XOR, 0110 SRL, 0111 SRA, 1000 OR, 1001 AND, 1010 PASS_B.
- immsel  out  3  000 I, 001 S, 010 B, 011 U, 100 J.
- br_un  out  1  unsigned compare (funct3[1]).
- RegWrite  out  1  regfile write enable.
- ResultSrc  out  2  00 ALU, 01 memory data, 10 PC (already PC+4).
- retire  out  1  one-cycle pulse per completed instruction.
- illegal  out  1  sticky: unsupported opcode/funct.
- bus_err  out  1  sticky: memory watchdog expired.
- state  out  3  current state, for debug.

Behaviour:
- States: RST=000, FETCH=001, DECODE=010, EXEC=011, MEM=100, WB=101, TRAP=110.
- State and watchdog counter are registered. Outputs are decoded combinationally from state plus IR fields.
- Unlisted outputs are 0 in every state.
- While rst_n=0 (asynchronous): state=RST, counter=0, illegal=0, bus_err=0, and all outputs are 0.
- RST: all outputs 0; go to FETCH unconditionally on the next edge.
- FETCH: mem_req=1, addr_sel=0.
  - On mem_ready: ir_write=1, pc_write=1, pc_src=0, then DECODE.
  - Otherwise stay in FETCH.
- DECODE, 1 cycle: immsel is valid.
  - Supported opcodes: 0110011, 0010011, 0000011, 0100011, 1100011, 1101111, 1100111, 0110111, 0010111.
  - Any other opcode, branch funct3 010/011, or R-type funct7 not in {0000000, 0100000 (SUB/SRA only)} -> TRAP.
  - All other cases -> EXEC.
- EXEC, by opcode:
  - R-type: alu_src_a=0, alu_src_b=0; ALUop from funct3/funct7[5]; next WB.
  - I-ALU: alu_src_b=1. funct7[5] selects SRA only when funct3=101; ADDI never becomes SUB. Next WB.
  - LOAD/STORE: ADD, alu_src_b=1; next MEM.
  - BRANCH: alu_src_a=1, alu_src_b=1, ADD, br_un=funct3[1].
    - Taken = BEQ brEq, BNE !brEq, BLT/BLTU brLt, BGE/BGEU !brLt.
    - If taken: pc_write=1, pc_src=1.
    - retire=1; next FETCH.
  - JAL (alu_src_a=1) / JALR (alu_src_a=0): alu_src_b=1, ADD, pc_write=1, pc_src=1, RegWrite=1, ResultSrc=10, retire=1; next FETCH.
  - LUI: alu_src_b=1, PASS_B; next WB.
  - AUIPC: alu_src_a=1, alu_src_b=1, ADD; next WB.
- MEM: mem_req=1, addr_sel=1, mem_we=(opcode==STORE).
  - Wait for mem_ready.
  - Store then retire=1 and go to FETCH; load then go to WB.
- WB: RegWrite=1, ResultSrc=01 for load, 00 otherwise; retire=1; next FETCH.
- Latency with zero-wait memory: R/I/LUI/AUIPC 4 cycles, load 5, store 4, branch/JAL/JALR 3.
- Watchdog:
  - Counter clears on entering FETCH or MEM and increments each waiting cycle.
  - If it reaches TIMEOUT without mem_ready: bus_err=1, go to TRAP.
  - mem_ready on the TIMEOUT cycle wins; no error is raised.
- TRAP: all outputs 0 except illegal/bus_err, which stay set. Exit is by reset only.
- Reset asserted mid-instruction aborts immediately; no partial pc_write/RegWrite is issued after reset deassertion.

Test Plan:
- Reset held 3 cycles, then released, mem_ready=1 -> state 000 then 001, mem_req=1 in first FETCH, all other outputs 0 during reset.
- ADD (0110011/000/0000000) with mem_ready=1 -> states 001,010,011,101; EXEC ALUop=0000, alu_src_b=0; WB RegWrite=1, ResultSrc=00; retire once.
- LW with mem_ready delayed 3 cycles in MEM -> MEM held 4 cycles, addr_sel=1, mem_we=0; WB ResultSrc=01; total 8 cycles.
- BNE with brEq=1, then brEq=0 -> first: no pc_write in EXEC; second: pc_write=1, pc_src=1, alu_src_a=1, immsel=010.
- Opcode 1111111 -> DECODE then TRAP, illegal=1, no RegWrite/pc_write; stays in TRAP until rst_n low.
- mem_ready never asserted in FETCH, TIMEOUT=200 -> bus_err=1 after 200 wait cycles, state=110, mem_req drops to 0.
